seq_sub64: RTL and testbench

- Multi-cycle 64-bit unsigned/two's-complement subtractor: diff = a - b - b_in (mod 2^64), with borrow-out and signed overflow.
- Inverse-direction companion to the 64-bit ripple-carry adder.
- Processes one CHUNK-bit slice per clock, LSB slice first, and ripples the borrow through a registered borrow flop.
- Sits beside the adder in the lab datapath. Uses a start/busy/done handshake so the datapath can issue operands and collect results.

---
 rtl/sub_pkg.sv | 13 +
 rtl/seq_sub64_slice_sub.sv | 19 +
 rtl/seq_sub64.sv | 101 ++++++++++
 tb/tb_seq_sub64.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared constants and FSM encoding for the sequential slice-wise subtractor.
package sub_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned CHUNK_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_sub64_slice_sub.sv
// Combinational CHUNK-bit subtract: d = x - y - bi, bo set when the result went negative.
module slice_sub #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
);

  logic [CHUNK:0] t;

  // One extra bit catches the borrow out of the slice.
  assign t  = {1'b0, x} - {1'b0, y} - (CHUNK+1)'(bi);
  assign d  = t[CHUNK-1:0];
  assign bo = t[CHUNK];

endmodule

// File: rtl/seq_sub64.sv
// Multi-cycle subtractor: one CHUNK-bit slice per clock, LSB first, borrow rippled through a flop.
module seq_sub64
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] slice_d;
  logic             slice_bo;
  logic             last_slice;

  // Counter-selected operand slices feed the single shared slice subtractor.
  assign a_sl       = a_q[cnt*CHUNK +: CHUNK];
  assign b_sl       = b_q[cnt*CHUNK +: CHUNK];
  assign last_slice = (cnt == CW'(NSLICE - 1));

  slice_sub #(.CHUNK(CHUNK)) u_slice (
    .x  (a_sl),
    .y  (b_sl),
    .bi (borrow),
    .d  (slice_d),
    .bo (slice_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      b_out  <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= b_in;
            cnt    <= '0;
            diff   <= '0;
            b_out  <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          diff[cnt*CHUNK +: CHUNK] <= slice_d;
          borrow                   <= slice_bo;
          cnt                      <= cnt + CW'(1);
          // Final slice: flags are resolved on the same edge so they are valid with done.
          if (last_slice) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            b_out <= slice_bo;
            ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_d[CHUNK-1] != a_q[WIDTH-1]);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sub64.sv
// Randomized self-checking bench for seq_sub64 against an arithmetic reference model.
module tb_seq_sub64;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned NSLICE = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;

  int n_checks = 0;
  int n_errors = 0;

  seq_sub64 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge in the IDLE cycle after DONE.
  task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic bi,
                        input int inj_cycle, input bit start_in_done);
    logic [64:0] m;
    logic        exp_ovf;
    int          busy_cycles;
    int          waited;
    bit          seen;

    m       = {1'b0, av} - {1'b0, bv} - 65'(bi);
    exp_ovf = (av[63] != bv[63]) && (m[63] != av[63]);

    a = av; b = bv; b_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = rnd64(); b = rnd64(); b_in = 1'($urandom());

    busy_cycles = 0;
    waited      = 0;
    seen        = 1'b0;
    while (!seen && waited < 20) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        if (busy_cycles == inj_cycle && busy) begin
          start = 1'b1; a = rnd64(); b = rnd64(); b_in = 1'($urandom());
        end
        @(negedge clk);
        start = 1'b0;
        waited++;
      end
    end

    check("done_seen", 64'(seen), 64'd1);
    check("busy_cycles", 64'(busy_cycles), 64'(NSLICE));
    check("busy_in_done", 64'(busy), 64'd0);
    check("diff", diff, m[63:0]);
    check("b_out", 64'(b_out), 64'(m[64]));
    check("ovf", 64'(ovf), 64'(exp_ovf));

    if (start_in_done) begin
      start = 1'b1; a = rnd64(); b = rnd64(); b_in = 1'($urandom());
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_width", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
    check("diff_hold", diff, m[63:0]);
  endtask

  initial begin
    bit late_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_diff", diff, 64'd0);
    check("rst_b_out", 64'(b_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(64'h6A, 64'h4, 1'b0, -1, 1'b0);
    run_op(64'hF, 64'hF, 1'b1, -1, 1'b0);
    run_op(64'h0, 64'h1, 1'b0, -1, 1'b0);
    run_op(64'h508BBE0301D2D287, 64'hDF181EA770DB8BB5, 1'b0, -1, 1'b0);
    run_op(64'h8000000000000000, 64'h1, 1'b0, -1, 1'b0);
    run_op(64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, -1, 1'b0);
    run_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, -1, 1'b0);

    // Restart mid-run and during DONE must be ignored; the following IDLE start is taken.
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 3, 1'b1);
    run_op(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, -1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_op(rnd64(), rnd64(), 1'($urandom()), ((i % 4) == 0) ? int'($urandom_range(1, 7)) : -1,
             (i % 3) == 0);
    end

    // Abort in the fourth RUN cycle.
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1111_1111_1111_1111; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_diff", diff, 64'd0);
    check("abort_b_out", 64'(b_out), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    late_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) late_done = 1'b1;
    end
    check("abort_no_done", 64'(late_done), 64'd0);

    run_op(64'h6A, 64'h4, 1'b0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
